// File: rtl/l1_mmu_responder.sv
// Responder side of the L1<->MMU line interface: serialises 32B cached lines into
// eight word beats (or one beat for MMIO) on a word-wide memory bus.
module l1_mmu_responder #(
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
    parameter logic [31:0] MMIO_MASK = 32'hFFFF_0000,
    parameter logic [15:0] TIMEOUT   = 16'd1023
) (
    input  logic         sys_clk,
    input  logic         rst,
    input  logic         l1_mmu_req_read,
    input  logic         l1_mmu_req_write,
    input  logic [31:0]  l1_mmu_req_addr,
    input  logic [255:0] l1_mmu_write_data,
    output logic         mmu_l1_done,
    output logic [255:0] mmu_l1_read_data,
    output logic         mmu_err,
    output logic         mem_req,
    output logic         mem_we,
    output logic [31:0]  mem_addr,
    output logic [31:0]  mem_wdata,
    input  logic         mem_ack,
    input  logic [31:0]  mem_rdata
);

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned LW   = 256;
    localparam int unsigned BW   = 3;
    localparam int unsigned TW   = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BEAT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e          state_q;
    logic            op_wr_q;
    logic            is_mmio_q;
    logic [AW-1:0]   addr_q;
    logic [LW-1:0]   line_q;
    logic [BW-1:0]   beat_q;
    logic [TW-1:0]   wait_q;

    logic            done_q;
    logic [LW-1:0]   rdata_q;
    logic            err_q;
    logic            mem_req_q;
    logic            mem_we_q;
    logic [AW-1:0]   mem_addr_q;
    logic [DW-1:0]   mem_wdata_q;

    logic            req_mmio_c;
    logic            timeout_c;
    logic            beat_end_c;
    logic            last_beat_c;
    logic [BW-1:0]   beat_d;
    logic [DW-1:0]   rword_c;

    // Word address for a given beat; MMIO passes the request address through untouched.
    function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] a,
                                                input logic          mmio,
                                                input logic [BW-1:0] b);
        return mmio ? a : {a[AW-1:5], b, 2'b00};
    endfunction

    always_comb begin
        req_mmio_c  = (l1_mmu_req_addr & MMIO_MASK) == MMIO_BASE;
        timeout_c   = (TIMEOUT != '0) && !mem_ack && (wait_q == TIMEOUT - TW'(1));
        beat_end_c  = mem_ack || timeout_c;
        last_beat_c = is_mmio_q ? (beat_q == '0) : (beat_q == BW'(7));
        beat_d      = BW'(beat_q + BW'(1));
        // A timed-out read beat returns zero rather than stale bus data.
        rword_c     = mem_ack ? mem_rdata : '0;
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_wr_q     <= 1'b0;
            is_mmio_q   <= 1'b0;
            addr_q      <= '0;
            line_q      <= '0;
            beat_q      <= '0;
            wait_q      <= '0;
            done_q      <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (l1_mmu_req_write || l1_mmu_req_read) begin
                        op_wr_q    <= l1_mmu_req_write;
                        addr_q     <= l1_mmu_req_addr;
                        is_mmio_q  <= req_mmio_c;
                        beat_q     <= '0;
                        wait_q     <= '0;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= l1_mmu_req_write;
                        mem_addr_q <= beat_addr(l1_mmu_req_addr, req_mmio_c, '0);
                        if (l1_mmu_req_write) begin
                            line_q      <= l1_mmu_write_data;
                            mem_wdata_q <= l1_mmu_write_data[DW-1:0];
                        end else begin
                            mem_wdata_q <= line_q[DW-1:0];
                        end
                        state_q    <= ST_BEAT;
                    end
                end
                ST_BEAT: begin
                    if (beat_end_c) begin
                        if (timeout_c) begin
                            err_q <= 1'b1;
                        end
                        if (!op_wr_q) begin
                            if (is_mmio_q) begin
                                rdata_q <= {224'b0, rword_c};
                            end else begin
                                rdata_q[{beat_q, 5'd0} +: DW] <= rword_c;
                            end
                        end
                        if (last_beat_c) begin
                            mem_req_q <= 1'b0;
                            mem_we_q  <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= ST_DONE;
                        end else begin
                            beat_q      <= beat_d;
                            wait_q      <= '0;
                            mem_addr_q  <= beat_addr(addr_q, is_mmio_q, beat_d);
                            mem_wdata_q <= line_q[{beat_d, 5'd0} +: DW];
                        end
                    end else begin
                        wait_q <= TW'(wait_q + TW'(1));
                    end
                end
                ST_DONE: begin
                    // One idle cycle follows so a request still held high is not re-served.
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q    <= 1'b0;
                    mem_req_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign mmu_l1_done      = done_q;
    assign mmu_l1_read_data = rdata_q;
    assign mmu_err          = err_q;
    assign mem_req          = mem_req_q;
    assign mem_we           = mem_we_q;
    assign mem_addr         = mem_addr_q;
    assign mem_wdata        = mem_wdata_q;

endmodule

// File: tb/tb_l1_mmu_responder.sv
// Bench for l1_mmu_responder: table-driven directed transactions, random traffic against
// a transaction-level model, plus handwritten reset, back-to-back and timeout sequences.
module tb_l1_mmu_responder;

    logic         sys_clk;
    logic         rst;
    logic         l1_mmu_req_read;
    logic         l1_mmu_req_write;
    logic [31:0]  l1_mmu_req_addr;
    logic [255:0] l1_mmu_write_data;
    logic         mmu_l1_done;
    logic [255:0] mmu_l1_read_data;
    logic         mmu_err;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic         mem_ack;
    logic [31:0]  mem_rdata;

    l1_mmu_responder #(
        .MMIO_BASE (32'hFFFF_0000),
        .MMIO_MASK (32'hFFFF_0000),
        .TIMEOUT   (16'd4)
    ) dut (
        .sys_clk           (sys_clk),
        .rst               (rst),
        .l1_mmu_req_read   (l1_mmu_req_read),
        .l1_mmu_req_write  (l1_mmu_req_write),
        .l1_mmu_req_addr   (l1_mmu_req_addr),
        .l1_mmu_write_data (l1_mmu_write_data),
        .mmu_l1_done       (mmu_l1_done),
        .mmu_l1_read_data  (mmu_l1_read_data),
        .mmu_err           (mmu_err),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_ack           (mem_ack),
        .mem_rdata         (mem_rdata)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } beat_t;

    typedef struct {
        string       nm;
        bit          wr;
        logic [31:0] addr;
        int          waits;
        int          mode;
        int          exp_lat;
        int          exp_nb;
    } vec_t;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    int           done_cnt = 0;
    int           last_done_cyc = 0;
    int           wait_n   = 0;
    int           wcnt     = 0;
    int           mode     = 0;
    bit           ack_en   = 1'b1;
    beat_t        beats[$];
    logic [255:0] exp_rd   = '0;

    // Memory contents as seen by the bench: selectable per test.
    function automatic logic [31:0] mdata(input logic [31:0] a);
        case (mode)
            1:       return 32'hA0 + {29'b0, a[4:2]};
            2:       return 32'hDEAD_BEEF;
            default: return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
        endcase
    endfunction

    function automatic bit is_mmio(input logic [31:0] a);
        return (a & 32'hFFFF_0000) == 32'hFFFF_0000;
    endfunction

    // Memory responder and done/beat monitor, evaluated on the falling edge.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge sys_clk);
            cyc++;
            if (mem_req && ack_en) begin
                if (wcnt == wait_n) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mdata(mem_addr);
                    wcnt      = 0;
                    beats.push_back('{we: mem_we, addr: mem_addr, wdata: mem_wdata});
                end else begin
                    mem_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_ack = 1'b0;
                wcnt    = 0;
            end
            if (mmu_l1_done) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no end expected end");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one transaction to completion and check it against the model.
    task automatic run_txn(input string nm, input bit wr, input logic [31:0] addr,
                           input logic [255:0] line, input int waits,
                           input int exp_lat, input int exp_nb, input bit exp_err);
        int          start;
        bit          got;
        bit          mm;
        logic [31:0] a;
        mm        = is_mmio(addr);
        wait_n    = waits;
        beats.delete();
        done_cnt  = 0;
        l1_mmu_req_addr   = addr;
        l1_mmu_write_data = line;
        l1_mmu_req_write  = wr;
        l1_mmu_req_read   = !wr;
        start = cyc;
        got   = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            tick();
            if (done_cnt != 0) got = 1'b1;
        end
        l1_mmu_req_read  = 1'b0;
        l1_mmu_req_write = 1'b0;
        chk({nm, " done seen"}, 256'(got), 256'(1));
        chk({nm, " latency"}, 256'(last_done_cyc - start), 256'(exp_lat));
        if (!wr) begin
            for (int i = 0; i < (mm ? 1 : 8); i++) begin
                a = mm ? addr : {addr[31:5], 3'(i), 2'b00};
                if (mm) exp_rd = {224'b0, mdata(a)};
                else    exp_rd[32*i +: 32] = mdata(a);
            end
        end
        chk({nm, " read_data@done"}, mmu_l1_read_data, exp_rd);
        tick();
        tick();
        chk({nm, " done pulses"}, 256'(done_cnt), 256'(1));
        chk({nm, " beats"}, 256'(beats.size()), 256'(exp_nb));
        for (int i = 0; i < beats.size() && i < 8; i++) begin
            a = mm ? addr : {addr[31:5], 3'(i), 2'b00};
            chk($sformatf("%s beat%0d addr", nm, i), 256'(beats[i].addr), 256'(a));
            chk($sformatf("%s beat%0d we", nm, i), 256'(beats[i].we), 256'(wr));
            if (wr) chk($sformatf("%s beat%0d wdata", nm, i), 256'(beats[i].wdata),
                        256'(line[32*i +: 32]));
        end
        chk({nm, " read_data hold"}, mmu_l1_read_data, exp_rd);
        chk({nm, " err"}, 256'(mmu_err), 256'(exp_err));
    endtask

    vec_t         tbl[6];
    logic [255:0] pat;
    logic [255:0] rline;
    logic [31:0]  raddr;
    bit           got;
    int           start;

    initial begin
        for (int i = 0; i < 8; i++) pat[32*i +: 32] = 32'h1000 + i;
        tbl[0] = '{"crd_1234",  1'b0, 32'h0000_1234, 0, 1, 9,  8};
        tbl[1] = '{"cwr_8000",  1'b1, 32'h0000_8000, 2, 0, 25, 8};
        tbl[2] = '{"mrd_0004",  1'b0, 32'hFFFF_0004, 0, 2, 2,  1};
        tbl[3] = '{"mwr_0010",  1'b1, 32'hFFFF_0010, 1, 0, 3,  1};
        tbl[4] = '{"crd_001F",  1'b0, 32'h0000_001F, 1, 0, 17, 8};
        tbl[5] = '{"crd_FFFE",  1'b0, 32'hFFFE_FFE0, 0, 0, 9,  8};

        rst = 1'b1;
        l1_mmu_req_read   = 1'b0;
        l1_mmu_req_write  = 1'b0;
        l1_mmu_req_addr   = '0;
        l1_mmu_write_data = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst mem_req",   256'(mem_req),   256'(0));
        chk("rst mem_we",    256'(mem_we),    256'(0));
        chk("rst mem_addr",  256'(mem_addr),  256'(0));
        chk("rst mem_wdata", 256'(mem_wdata), 256'(0));
        chk("rst done",      256'(mmu_l1_done), 256'(0));
        chk("rst read_data", mmu_l1_read_data, 256'(0));
        chk("rst err",       256'(mmu_err),   256'(0));

        for (int v = 0; v < 6; v++) begin
            mode = tbl[v].mode;
            run_txn(tbl[v].nm, tbl[v].wr, tbl[v].addr, pat, tbl[v].waits,
                    tbl[v].exp_lat, tbl[v].exp_nb, 1'b0);
            if (tbl[v].mode == 1)
                for (int w = 0; w < 8; w++)
                    chk($sformatf("A0 word%0d", w), 256'(mmu_l1_read_data[32*w +: 32]),
                        256'(32'hA0 + w));
            if (tbl[v].mode == 2)
                chk("mmio DEADBEEF", mmu_l1_read_data, {224'b0, 32'hDEAD_BEEF});
        end
        mode = 0;

        // Writeback held until done, then a read: one idle gap, then the read beats.
        wait_n = 0;
        beats.delete();
        done_cnt = 0;
        l1_mmu_req_addr   = 32'h0000_5000;
        l1_mmu_write_data = pat;
        l1_mmu_req_write  = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            tick();
            if (done_cnt != 0) got = 1'b1;
        end
        chk("wbrd first done", 256'(got), 256'(1));
        l1_mmu_req_write = 1'b0;
        l1_mmu_req_read  = 1'b1;
        l1_mmu_req_addr  = 32'h0000_2000;
        chk("wbrd req in done", 256'(mem_req), 256'(0));
        tick();
        chk("wbrd req in gap", 256'(mem_req), 256'(0));
        chk("wbrd done in gap", 256'(mmu_l1_done), 256'(0));
        tick();
        chk("wbrd rd req", 256'(mem_req), 256'(1));
        chk("wbrd rd we", 256'(mem_we), 256'(0));
        chk("wbrd rd addr", 256'(mem_addr), 256'(32'h0000_2000));
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            tick();
            if (done_cnt == 2) got = 1'b1;
        end
        l1_mmu_req_read = 1'b0;
        chk("wbrd second done", 256'(got), 256'(1));
        tick();
        tick();
        chk("wbrd done pulses", 256'(done_cnt), 256'(2));
        chk("wbrd beats", 256'(beats.size()), 256'(16));
        for (int i = 0; i < beats.size() && i < 16; i++)
            chk($sformatf("wbrd beat%0d we", i), 256'(beats[i].we), 256'(i < 8));
        for (int i = 0; i < 8; i++) exp_rd[32*i +: 32] = mdata({27'h100, 3'(i), 2'b00});
        chk("wbrd read_data", mmu_l1_read_data, exp_rd);

        // Random traffic against the transaction-level model.
        for (int t = 0; t < 24; t++) begin
            for (int w = 0; w < 8; w++) rline[32*w +: 32] = $urandom();
            raddr = $urandom();
            if ($urandom_range(0, 3) == 0) raddr[31:16] = 16'hFFFF;
            else                           raddr[31]    = 1'b0;
            wait_n = $urandom_range(0, 2);
            run_txn($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), raddr, rline, wait_n,
                    1 + (is_mmio(raddr) ? 1 : 8) * (wait_n + 1),
                    is_mmio(raddr) ? 1 : 8, 1'b0);
        end

        // Memory never acks: every beat times out after four cycles and reads zero.
        ack_en = 1'b0;
        done_cnt = 0;
        l1_mmu_req_addr = 32'h0000_3000;
        l1_mmu_req_read = 1'b1;
        start = cyc;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            tick();
            if (done_cnt != 0) got = 1'b1;
        end
        l1_mmu_req_read = 1'b0;
        chk("tmo done seen", 256'(got), 256'(1));
        chk("tmo latency", 256'(last_done_cyc - start), 256'(33));
        chk("tmo err", 256'(mmu_err), 256'(1));
        chk("tmo read_data", mmu_l1_read_data, 256'(0));
        exp_rd = '0;
        tick();
        tick();
        chk("tmo err sticky", 256'(mmu_err), 256'(1));
        chk("tmo done pulses", 256'(done_cnt), 256'(1));
        ack_en = 1'b1;

        run_txn("refill", 1'b0, 32'h0000_6000, pat, 0, 9, 8, 1'b1);

        // Reset in the middle of a cached read aborts it without a done pulse.
        done_cnt = 0;
        wait_n = 0;
        l1_mmu_req_addr = 32'h0000_4000;
        l1_mmu_req_read = 1'b1;
        repeat (3) tick();
        chk("midrst in beat", 256'(mem_req), 256'(1));
        rst = 1'b1;
        l1_mmu_req_read = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("midrst mem_req",   256'(mem_req), 256'(0));
        chk("midrst done",      256'(mmu_l1_done), 256'(0));
        chk("midrst read_data", mmu_l1_read_data, 256'(0));
        chk("midrst err",       256'(mmu_err), 256'(0));
        repeat (20) tick();
        chk("midrst no done",   256'(done_cnt), 256'(0));
        chk("midrst idle req",  256'(mem_req), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
